// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module : video_timing_pkg
//  Brief  : Mode encoding, per-mode raster timing table and total-size helpers
//           shared by the video timing generator.
//  Rev    : 1.0  initial multi-mode release
// ============================================================================
package video_timing_pkg;

   // Internal counter widths: wide enough for every entry of the table.
   localparam int CNT_HW = 12;
   localparam int CNT_VW = 11;

   // Smallest output widths that still hold the largest count of any mode
   // (hcount up to 1649, vcount up to 805).
   localparam int MIN_H_W = 11;
   localparam int MIN_V_W = 10;

   typedef enum logic [1:0] {
      MODE_640X480  = 2'd0,
      MODE_800X600  = 2'd1,
      MODE_1024X768 = 2'd2,
      MODE_1280X720 = 2'd3
   } mode_t;

   typedef struct packed {
      logic [CNT_HW-1:0] w;
      logic [CNT_HW-1:0] h_fp;
      logic [CNT_HW-1:0] h_sync;
      logic [CNT_HW-1:0] h_bp;
      logic [CNT_VW-1:0] h;
      logic [CNT_VW-1:0] v_fp;
      logic [CNT_VW-1:0] v_sync;
      logic [CNT_VW-1:0] v_bp;
      logic              neg_pol;
   } timing_t;

   localparam timing_t TIMING_TABLE [4] = '{
      '{12'd640,  12'd16,  12'd96,  12'd48,  11'd480, 11'd10, 11'd2, 11'd33, 1'b1},
      '{12'd800,  12'd40,  12'd128, 12'd88,  11'd600, 11'd1,  11'd4, 11'd23, 1'b0},
      '{12'd1024, 12'd24,  12'd136, 12'd160, 11'd768, 11'd3,  11'd6, 11'd29, 1'b1},
      '{12'd1280, 12'd110, 12'd40,  12'd220, 11'd720, 11'd5,  11'd5, 11'd20, 1'b0}
   };

   function automatic logic [CNT_HW-1:0] h_total(timing_t t);
      return t.w + t.h_fp + t.h_sync + t.h_bp;
   endfunction

   function automatic logic [CNT_VW-1:0] v_total(timing_t t);
      return t.h + t.v_fp + t.v_sync + t.v_bp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
//  Module : sync_delay_line
//  Brief  : Clock-enabled 3-bit shift register of parametrised depth; reset
//           fills every stage with FILL. DEPTH=0 is a plain wire.
//  Rev    : 1.0  initial release
// ============================================================================
module sync_delay_line #(
   parameter int         DEPTH = 0,
   parameter logic [2:0] FILL  = 3'b001
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ce_i,
   input  logic [2:0] d_i,
   output logic [2:0] q_o
);

   if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_i, ce_i};
      assign q_o         = d_i;
   end else begin : g_shift
      logic [2:0] stage_q [DEPTH];

      // Shift one stage per pixel enable; reset preloads the idle level.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= FILL;
         end else if (ce_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module : video_timing_gen
//  Brief  : Four-mode raster timing generator with pixel enable, frame-aligned
//           mode switching and a configurable sync/blank delay line.
//  Rev    : 1.0  initial multi-mode release
// ============================================================================
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_W          = 12,
   parameter int V_W          = 11,
   parameter int DEFAULT_MODE = 2,
   parameter int DELAY        = 0,
   parameter int FC_W         = 16
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ce_in,
   input  logic [1:0]      mode_in,
   output logic [H_W-1:0]  hcount_out,
   output logic [V_W-1:0]  vcount_out,
   output logic            hsync_out,
   output logic            vsync_out,
   output logic            blank_out,
   output logic            line_start_out,
   output logic            frame_start_out,
   output logic [FC_W-1:0] frame_count_out,
   output logic [1:0]      mode_out
);

   if (H_W < MIN_H_W || V_W < MIN_V_W || DELAY < 0 || DELAY > 8) begin : g_bad_params
      $error("video_timing_gen: H_W/V_W too small or DELAY outside 0..8");
   end

   // Reset parks the raster on the last pixel of the default mode so the
   // first enabled cycle lands on (0,0) and counts as a frame start.
   localparam mode_t       RST_MODE = mode_t'(2'(DEFAULT_MODE));
   localparam timing_t     RST_T    = TIMING_TABLE[RST_MODE];
   localparam logic [CNT_HW-1:0] RST_H = h_total(RST_T) - 12'd1;
   localparam logic [CNT_VW-1:0] RST_V = v_total(RST_T) - 11'd1;
   // {hsync, vsync, blank} at idle: syncs inactive, blanked.
   localparam logic [2:0]  FILL     = {RST_T.neg_pol, RST_T.neg_pol, 1'b1};

   mode_t             mode_q, mode_d;
   logic [CNT_HW-1:0] hcount_q, hcount_d;
   logic [CNT_VW-1:0] vcount_q, vcount_d;
   logic [FC_W-1:0]   frame_count_q, frame_count_d;
   logic              line_start_q, line_start_d;
   logic              frame_start_q, frame_start_d;
   logic [2:0]        raw_q, raw_d;
   logic [2:0]        dly;

   timing_t cur_t, nxt_t;
   logic    h_wrap, v_wrap, frame_wrap;
   logic    hs_act, vs_act, blank;

   // Next raster position, mode adoption at the frame wrap, and the sync /
   // blank decode of that next position so it registers alongside the counts.
   always_comb begin
      cur_t      = TIMING_TABLE[mode_q];
      h_wrap     = (hcount_q == h_total(cur_t) - 12'd1);
      v_wrap     = (vcount_q == v_total(cur_t) - 11'd1);
      frame_wrap = h_wrap && v_wrap;

      mode_d        = frame_wrap ? mode_t'(mode_in) : mode_q;
      hcount_d      = h_wrap ? '0 : hcount_q + 12'd1;
      vcount_d      = vcount_q;
      if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + 11'd1;
      frame_count_d = frame_wrap ? frame_count_q + FC_W'(1) : frame_count_q;

      nxt_t  = TIMING_TABLE[mode_d];
      hs_act = (hcount_d >= nxt_t.w + nxt_t.h_fp) &&
               (hcount_d <  nxt_t.w + nxt_t.h_fp + nxt_t.h_sync);
      vs_act = (vcount_d >= nxt_t.h + nxt_t.v_fp) &&
               (vcount_d <  nxt_t.h + nxt_t.v_fp + nxt_t.v_sync);
      blank  = (hcount_d >= nxt_t.w) || (vcount_d >= nxt_t.h);
      raw_d  = {hs_act ^ nxt_t.neg_pol, vs_act ^ nxt_t.neg_pol, blank};

      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
   end

   // Raster state; deassertion of rst_in is expected to be synchronous to clk_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q        <= RST_MODE;
         hcount_q      <= RST_H;
         vcount_q      <= RST_V;
         frame_count_q <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         raw_q         <= FILL;
      end else if (ce_in) begin
         mode_q        <= mode_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_count_q <= frame_count_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         raw_q         <= raw_d;
      end
   end

   sync_delay_line #(
      .DEPTH (DELAY),
      .FILL  (FILL)
   ) u_sync_delay (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .ce_i  (ce_in),
      .d_i   (raw_q),
      .q_o   (dly)
   );

   assign hcount_out      = H_W'(hcount_q);
   assign vcount_out      = V_W'(vcount_q);
   assign hsync_out       = dly[2];
   assign vsync_out       = dly[1];
   assign blank_out       = dly[0];
   assign line_start_out  = line_start_q;
   assign frame_start_out = frame_start_q;
   assign frame_count_out = frame_count_q;
   assign mode_out        = mode_q;

endmodule
`default_nettype wire
